// File: rtl/phase_mixer.sv
// Sign-magnitude shift-add multiplier that mixes an ADC sample with a reference
// sample, one multiplier bit per qzt_clk, for the downstream low-pass filter.
module phase_mixer #(
   parameter bit OFFSET_BIN = 1'b0
) (
   input  logic        qzt_clk,
   input  logic        rst_n,
   input  logic        clk_in,
   input  logic [13:0] adc_in,
   input  logic [13:0] ref_in,
   output logic [27:0] Vout,
   output logic        clk_out,
   output logic        busy,
   output logic        overrun
);

   localparam int unsigned DW = 14;
   localparam int unsigned PW = 27;
   localparam int unsigned OW = 28;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t        state;
   logic          clk_in_old;
   logic [PW-1:0] acc;
   logic [PW-1:0] mcand;
   logic [DW-1:0] mplier;
   logic [CW-1:0] count;
   logic          res_sign;

   logic          edge_det;
   logic [DW-1:0] adc_tc;
   logic [DW-1:0] adc_mag;
   logic [DW-1:0] ref_mag;
   logic [OW-1:0] acc_ext;

   // Operand conditioning: two's complement to magnitude (|-8192| still fits 14 bits)
   always_comb begin
      edge_det = clk_in & ~clk_in_old;
      adc_tc   = adc_in;
      if (OFFSET_BIN) adc_tc[DW-1] = ~adc_in[DW-1];
      adc_mag  = adc_tc[DW-1] ? (~adc_tc + DW'(1)) : adc_tc;
      ref_mag  = ref_in[DW-1] ? (~ref_in + DW'(1)) : ref_in;
      acc_ext  = {1'b0, acc};
   end

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         clk_in_old <= 1'b0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         count      <= '0;
         res_sign   <= 1'b0;
         Vout       <= '0;
         clk_out    <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         clk_in_old <= clk_in;
         clk_out    <= 1'b0;
         case (state)
            IDLE: begin
               if (edge_det) begin
                  mcand    <= PW'(adc_mag);
                  mplier   <= ref_mag;
                  acc      <= '0;
                  res_sign <= adc_tc[DW-1] ^ ref_in[DW-1];
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= MUL;
               end
            end
            MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
               if (count == LAST_BIT) state <= DONE;
            end
            DONE: begin
               Vout    <= res_sign ? (~acc_ext + OW'(1)) : acc_ext;
               clk_out <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Edges arriving while a product is in flight are dropped but remembered
         if (edge_det && state != IDLE) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_phase_mixer.sv
// Directed bench for phase_mixer: two's-complement and offset-binary instances.
module tb_phase_mixer;

   logic        qzt_clk = 1'b0;
   logic        rst_n;
   logic        clk_in;
   logic [13:0] adc_in;
   logic [13:0] ref_in;
   logic [27:0] vout_a, vout_b;
   logic        clk_out_a, clk_out_b, busy_a, busy_b, overrun_a, overrun_b;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;

   always #5 qzt_clk = ~qzt_clk;

   phase_mixer #(.OFFSET_BIN(1'b0)) dut_a (
      .qzt_clk(qzt_clk), .rst_n(rst_n), .clk_in(clk_in), .adc_in(adc_in), .ref_in(ref_in),
      .Vout(vout_a), .clk_out(clk_out_a), .busy(busy_a), .overrun(overrun_a));

   phase_mixer #(.OFFSET_BIN(1'b1)) dut_b (
      .qzt_clk(qzt_clk), .rst_n(rst_n), .clk_in(clk_in), .adc_in(adc_in), .ref_in(ref_in),
      .Vout(vout_b), .clk_out(clk_out_b), .busy(busy_b), .overrun(overrun_b));

   always @(negedge qzt_clk) if (clk_out_a) pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One product: latency, busy width, value, single-cycle strobe
   task automatic run_one(input string tag, input bit ob, input logic [13:0] a,
                          input logic [13:0] r, input logic [27:0] exp);
      int n;
      int busy_cyc;
      @(negedge qzt_clk);
      adc_in = a; ref_in = r; clk_in = 1'b1;
      @(posedge qzt_clk); #1;
      busy_cyc = (ob ? busy_b : busy_a) ? 1 : 0;
      clk_in = 1'b0; adc_in = ~a; ref_in = ~r;
      n = 0;
      while (!(ob ? clk_out_b : clk_out_a) && n < 40) begin
         @(posedge qzt_clk); #1;
         n++;
         if (ob ? busy_b : busy_a) busy_cyc++;
      end
      check({tag, "_latency"}, n, 15);
      check({tag, "_busy_cycles"}, busy_cyc, 15);
      check({tag, "_vout"}, ob ? vout_b : vout_a, exp);
      @(posedge qzt_clk); #1;
      check({tag, "_strobe_low"}, ob ? clk_out_b : clk_out_a, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, n, ai, ri;
      logic [27:0] exp;
      rst_n = 1'b0; clk_in = 1'b0; adc_in = '0; ref_in = '0;
      #23;
      check("rst_vout", vout_a, 0);
      check("rst_clk_out", clk_out_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_overrun", overrun_a, 0);
      @(negedge qzt_clk); rst_n = 1'b1;
      repeat (2) @(negedge qzt_clk);

      run_one("basic", 1'b0, 14'(100), 14'(-50), 28'hFFFEC78);
      run_one("maxneg", 1'b0, 14'h2000, 14'h2000, 28'h4000000);
      run_one("maxmix", 1'b0, 14'(8191), 14'h2000, 28'hC002000);
      run_one("zero_neg", 1'b0, 14'(0), 14'(-1), 28'h0);
      run_one("m1m1", 1'b0, 14'(-1), 14'(-1), 28'h1);
      run_one("offbin", 1'b1, 14'h2064, 14'(3), 28'd300);

      // Back-to-back samples at the minimum period
      p0 = pulses;
      @(negedge qzt_clk);
      for (int i = 0; i < 10; i++) begin
         ai = i * 1234 - 6000;
         ri = 4000 - i * 777;
         exp = 28'(ai * ri);
         adc_in = 14'(ai); ref_in = 14'(ri); clk_in = 1'b1;
         for (int j = 0; j < 16; j++) begin
            @(negedge qzt_clk);
            if (j == 0) begin
               clk_in = 1'b0; adc_in = 14'($urandom); ref_in = 14'($urandom);
            end
         end
         check($sformatf("b2b_vout_%0d", i), vout_a, exp);
         check($sformatf("b2b_strobe_%0d", i), clk_out_a, 1);
      end
      @(negedge qzt_clk);
      check("b2b_pulses", pulses - p0, 10);
      check("b2b_overrun", overrun_a, 0);

      // Second edge 5 cycles into a multiply
      p0 = pulses;
      @(negedge qzt_clk);
      adc_in = 14'(100); ref_in = 14'(-50); clk_in = 1'b1;
      for (int j = 0; j < 25; j++) begin
         @(negedge qzt_clk);
         clk_in = (j == 4);
      end
      check("ovr_flag", overrun_a, 1);
      check("ovr_vout", vout_a, 28'hFFFEC78);
      check("ovr_pulses", pulses - p0, 1);

      // Reset mid-multiply
      p0 = pulses;
      @(negedge qzt_clk);
      adc_in = 14'(77); ref_in = 14'(55); clk_in = 1'b1;
      @(posedge qzt_clk); #1 clk_in = 1'b0;
      repeat (7) @(posedge qzt_clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_vout", vout_a, 0);
      check("arst_busy", busy_a, 0);
      check("arst_overrun", overrun_a, 0);
      adc_in = 14'(7); ref_in = 14'(-6); clk_in = 1'b1;
      repeat (20) @(negedge qzt_clk);
      check("arst_no_pulse", pulses - p0, 0);
      rst_n = 1'b1;
      n = 0;
      do begin
         @(posedge qzt_clk); #1;
         n++;
         clk_in = 1'b0;
      end while (!clk_out_a && n < 40);
      check("rel_high_latency", n, 16);
      check("rel_high_vout", vout_a, 28'hFFFFFD6);
      run_one("after_rst", 1'b0, 14'(-123), 14'(45), 28'(-5535));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_mixer.md
PHASE_MIXER -- requirements
Module: phase_mixer

Interface
REQ-001 SHALL provide parameter OFFSET_BIN, default 0, meaning 1 = adc_in is offset-binary (MSB inverted before use) and 0 = adc_in is two's complement.
REQ-002 SHALL provide port qzt_clk, input, 1, sole system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port clk_in, input, 1, sample strobe; a new sample is signalled by its 0->1 transition.
REQ-005 SHALL provide port adc_in, input, 14, signal sample.
REQ-006 SHALL provide port ref_in, input, 14, signed two's-complement reference (sine or cosine) sample.
REQ-007 SHALL provide port Vout, output, 28, signed product adc*ref, sign-extended; this feeds the low-pass filter Vin.
REQ-008 SHALL provide port clk_out, output, 1, product-ready strobe; this feeds the low-pass filter clk_in.
REQ-009 SHALL provide port busy, output, 1, high while a multiply is in progress.
REQ-010 SHALL provide port overrun, output, 1, sticky flag marking a sample edge lost while busy.

Function
REQ-011 SHALL register clk_in into clk_in_old every qzt_clk edge; edge detect = clk_in & !clk_in_old, evaluated before the update.
REQ-012 SHALL implement FSM states IDLE, MUL, DONE.
REQ-013 IDLE with edge detected SHALL capture operands, set busy=1, count=0, and go to MUL.
- Capture converts adc_in (MSB inverted if OFFSET_BIN=1) and ref_in to 14-bit unsigned magnitudes plus sign bits.
- Result sign = XOR of the two sign bits.
REQ-014 IDLE without an edge SHALL hold all state.
REQ-015 MUL SHALL process one multiplier bit per cycle (shift-add into 27-bit unsigned accumulator, LSB first), count 0..13.
- When count=13 is processed, go to DONE.
REQ-016 DONE SHALL load Vout with the accumulator (negated if result sign=1), zero-extended to 28 bits before negation.
- Same edge: pulse clk_out=1, set busy=0, return to IDLE.
REQ-017 Latency SHALL be exactly 15 qzt_clk edges from the capture edge to the edge that updates Vout and raises clk_out.
REQ-018 clk_out SHALL be high for exactly one qzt_clk cycle per product and low otherwise.
REQ-019 Vout SHALL hold its value between DONE updates.
REQ-020 A clk_in rising edge detected in MUL or DONE SHALL be dropped and SHALL set overrun=1.
- Operands in flight and the FSM are unaffected.
- overrun clears only on reset.
REQ-021 Minimum sample period SHALL be 16 qzt_clk cycles; the block accepts back-to-back edges at that rate without overrun.
REQ-022 Arithmetic SHALL be exact for all operand pairs.
- Extreme: -8192 * -8192 = +67108864 (28'h4000000); no saturation is needed.
- Zero result with sign=1 SHALL yield 0 (negation of zero).
REQ-023 adc_in and ref_in changes outside the capture edge SHALL NOT affect the result in flight.

Reset
REQ-024 rst_n low SHALL immediately force all registers to their reset values, independent of qzt_clk.
- State=IDLE, Vout=0, clk_out=0, busy=0, overrun=0.
- clk_in_old=0, accumulator, count and operand registers=0.
REQ-025 Reset asserted mid-multiply SHALL abort it, with no clk_out pulse and Vout=0.
REQ-026 After rst_n deasserts, if clk_in is already high, the first qzt_clk edge SHALL count as a rising edge and start a multiply.

Verification
REQ-027 Bench SHALL cover: OFFSET_BIN=0, adc_in=100, ref_in=-50, clk_in 0->1 -> Vout=28'hFFFEC78 (-5000), clk_out one-cycle pulse 15 edges after capture, busy high for 15 cycles.
REQ-028 Bench SHALL cover: adc_in=-8192, ref_in=-8192 -> Vout=28'h4000000; then adc_in=8191, ref_in=-8192 -> Vout=28'hC002000 (-67100672).
REQ-029 Bench SHALL cover: adc_in=0, ref_in=-1 -> Vout=0; adc_in=-1, ref_in=-1 -> Vout=1.
REQ-030 Bench SHALL cover: OFFSET_BIN=1, adc_in=14'h2064 (+100), ref_in=3 -> Vout=300.
REQ-031 Bench SHALL cover: second clk_in rising edge 5 cycles after the first -> overrun=1, first product correct, only one clk_out pulse; edges 16 cycles apart for 10 samples -> overrun stays 0, 10 pulses.
REQ-032 Bench SHALL cover: rst_n pulled low at cycle 7 of a multiply -> outputs zero asynchronously, no clk_out pulse; after release the next edge yields a correct product.
